bridge_fifo: RTL

- Synchronous show-ahead FIFO that buffers AXI-side address/control and write-data words until the APB converter pops them.
- One instance serves as the address FIFO (push_A/pop_A), one as the write-data FIFO (push_D/pop_D), and one as the read-data return FIFO (push_D_read/pop_D_read).
- Provides full/empty status, occupancy, almost-full, and sticky overflow/underflow error flags for bridge debug.

---
 rtl/bridge_fifo_if.sv | 28 ++
 rtl/bridge_fifo.sv | 67 ++++++
 2 files changed

// File: rtl/bridge_fifo_if.sv
// Handshake and status bundle between a bridge_fifo and the logic that pushes/pops it.
// The master side drives push/pop/clr_err; the slave side (the FIFO) returns data and status.
interface bridge_fifo_if #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4
);
    logic                     push;
    logic [DATAWIDTH-1:0]     wdata;
    logic                     pop;
    logic [DATAWIDTH-1:0]     rdata;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic [$clog2(DEPTH):0]   count;
    logic                     clr_err;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output push, wdata, pop, clr_err,
        input  rdata, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, wdata, pop, clr_err,
        output rdata, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/bridge_fifo.sv
// Show-ahead FIFO buffering AXI-side address/data words for the APB converter.
// Wrap-bit pointers give full/empty without a separate counter register.
module bridge_fifo #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4,
    parameter int AF_LEVEL  = 3
) (
    input logic           clk,
    input logic           rst,
    bridge_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic                 overflow_q;
    logic                 underflow_q;

    logic                 full_c;
    logic                 empty_c;
    logic [PW-1:0]        count_c;
    logic                 push_ok;
    logic                 pop_ok;

    assign full_c  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty_c = (wptr == rptr);
    assign count_c = wptr - rptr;

    // A push into a full FIFO is fine when the head is leaving on the same edge.
    assign push_ok = bus.push & (~full_c | bus.pop);
    assign pop_ok  = bus.pop & ~empty_c;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr        <= '0;
            rptr        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            // A new error on the same edge as clr_err keeps the flag set.
            overflow_q  <= (bus.push & full_c & ~bus.pop) | (overflow_q & ~bus.clr_err);
            underflow_q <= (bus.pop & empty_c) | (underflow_q & ~bus.clr_err);
        end
    end

    assign bus.full        = full_c;
    assign bus.empty       = empty_c;
    assign bus.count       = count_c;
    assign bus.almost_full = (count_c >= PW'(AF_LEVEL));
    assign bus.rdata       = empty_c ? '0 : mem[rptr[AW-1:0]];
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule
